// File: rtl/video_pkg.sv
// Shared types and constants for the video source mux.
package video_pkg;

  localparam int unsigned FRAME_CNT_W    = 16;
  localparam bit          VS_ACTIVE_HIGH = 1'b1;

  typedef enum logic {
    ST_ACTIVE  = 1'b0,
    ST_PENDING = 1'b1
  } sel_state_t;

  // Width of a source index; a single source still needs one bit.
  function automatic int unsigned SEL_W(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/video_src_mux_vsync_edge_timeout.sv
// Frame-start detector for the active source plus sync-loss timeout.
// On a source switch the previous-VS register is reloaded from the new
// source so that the switch itself never looks like a frame start.
module vsync_edge_timeout #(
  parameter int unsigned TIMEOUT_CYC = 2000000
) (
  input  logic clk,
  input  logic rst,
  input  logic vs_cur,
  input  logic vs_reload,
  input  logic reload,
  output logic fs_c,
  output logic no_sync
);

  localparam int unsigned      CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  logic             vs_prev;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  assign fs_c = vs_cur & ~vs_prev;

  // Saturating count of cycles since the last frame start or switch.
  always_comb begin
    cnt_next = cnt;
    if (fs_c || reload) begin
      cnt_next = '0;
    end else if (cnt != CNT_MAX) begin
      cnt_next = cnt + CNT_W'(1);
    end
  end

  // vs_prev resets high so a source already in VS at reset release is not
  // mistaken for a frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_prev <= 1'b1;
      cnt     <= '0;
      no_sync <= 1'b0;
    end else begin
      vs_prev <= reload ? vs_reload : vs_cur;
      cnt     <= cnt_next;
      no_sync <= (cnt_next == CNT_MAX);
    end
  end

endmodule

// File: rtl/video_src_mux.sv
// Frame-aligned video source selector with capture strobe and frame counter.
// Optional build macro VIDEO_SRC_MUX_SWITCH_MUTE_EN blanks colour after a
// switch until the new source's first frame start.
module video_src_mux
  import video_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned COLOR_W     = 12,
  parameter bit          VS_POL      = VS_ACTIVE_HIGH,
  parameter int unsigned TIMEOUT_CYC = 2000000,
  parameter int unsigned INIT_SEL    = 0
) (
  input  logic                         sys_clk,
  input  logic                         rst,
  input  logic [SEL_W(NUM_SRC)-1:0]    sel_in,
  input  logic [NUM_SRC-1:0]           src_de,
  input  logic [NUM_SRC-1:0]           src_hs,
  input  logic [NUM_SRC-1:0]           src_vs,
  input  logic [NUM_SRC*COLOR_W-1:0]   src_r,
  input  logic [NUM_SRC*COLOR_W-1:0]   src_g,
  input  logic [NUM_SRC*COLOR_W-1:0]   src_b,
  input  logic                         capture_req,
  output logic                         vid_de,
  output logic                         vid_hs,
  output logic                         vid_vs,
  output logic [COLOR_W-1:0]           vid_r,
  output logic [COLOR_W-1:0]           vid_g,
  output logic [COLOR_W-1:0]           vid_b,
  output logic [SEL_W(NUM_SRC)-1:0]    sel_active,
  output logic                         switch_pending,
  output logic                         sel_invalid,
  output logic                         no_sync,
  output logic                         capture_pulse,
  output logic [FRAME_CNT_W-1:0]       frame_cnt
);

  localparam int unsigned SW = SEL_W(NUM_SRC);

  logic [SW-1:0]      sel_meta;
  logic [SW-1:0]      sel_sync;
  sel_state_t         state;
  logic               cap_pend;
  logic               vs_cur_c;
  logic               vs_new_c;
  logic               fs_c;
  logic               sel_diff_c;
  logic               switch_c;
  logic               cap_fire_c;
  logic               mute_c;
  logic [COLOR_W-1:0] r_c;
  logic [COLOR_W-1:0] g_c;
  logic [COLOR_W-1:0] b_c;

  // Two-flop synchroniser; the invalid flag is computed alongside so it
  // lines up with sel_sync.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sel_meta    <= SW'(INIT_SEL);
      sel_sync    <= SW'(INIT_SEL);
      sel_invalid <= 1'b0;
    end else begin
      sel_meta    <= sel_in;
      sel_sync    <= sel_meta;
      sel_invalid <= (32'(sel_meta) >= NUM_SRC);
    end
  end

  // Source mux, polarity-normalised VS and switch/capture decisions.
  always_comb begin
    vs_cur_c   = ~(src_vs[sel_active] ^ VS_POL);
    vs_new_c   = ~(src_vs[sel_sync] ^ VS_POL);
    sel_diff_c = ~sel_invalid && (sel_sync != sel_active);
    switch_c   = (state == ST_PENDING) && sel_diff_c && (fs_c || no_sync);
    cap_fire_c = fs_c && cap_pend && !switch_c;
    r_c        = src_r[32'(sel_active) * COLOR_W +: COLOR_W];
    g_c        = src_g[32'(sel_active) * COLOR_W +: COLOR_W];
    b_c        = src_b[32'(sel_active) * COLOR_W +: COLOR_W];
  end

  vsync_edge_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_vsync (
    .clk      (sys_clk),
    .rst      (rst),
    .vs_cur   (vs_cur_c),
    .vs_reload(vs_new_c),
    .reload   (switch_c),
    .fs_c     (fs_c),
    .no_sync  (no_sync)
  );

  // Selection FSM, frame counter and capture strobe.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state          <= ST_ACTIVE;
      sel_active     <= SW'(INIT_SEL);
      switch_pending <= 1'b0;
      frame_cnt      <= '0;
      cap_pend       <= 1'b0;
      capture_pulse  <= 1'b0;
    end else begin
      capture_pulse <= cap_fire_c;
      cap_pend      <= (cap_pend && !cap_fire_c) || capture_req;
      if (switch_c) begin
        frame_cnt  <= '0;
        sel_active <= sel_sync;
      end else if (fs_c) begin
        frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
      end
      case (state)
        ST_ACTIVE: begin
          if (sel_diff_c) begin
            state          <= ST_PENDING;
            switch_pending <= 1'b1;
          end
        end
        ST_PENDING: begin
          if (!sel_diff_c || switch_c) begin
            state          <= ST_ACTIVE;
            switch_pending <= 1'b0;
          end
        end
        default: begin
          state          <= ST_ACTIVE;
          switch_pending <= 1'b0;
        end
      endcase
    end
  end

`ifdef VIDEO_SRC_MUX_SWITCH_MUTE_EN
  logic mute;

  // Colour blanking from a switch until the new source's first frame start.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      mute <= 1'b0;
    end else if (switch_c) begin
      mute <= 1'b1;
    end else if (fs_c) begin
      mute <= 1'b0;
    end
  end

  assign mute_c = mute & ~fs_c;
`else
  assign mute_c = 1'b0;
`endif

  // Output register; every field comes from the same source in a cycle.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      vid_de <= 1'b0;
      vid_hs <= 1'b0;
      vid_vs <= 1'b0;
      vid_r  <= '0;
      vid_g  <= '0;
      vid_b  <= '0;
    end else begin
      vid_de <= src_de[sel_active];
      vid_hs <= src_hs[sel_active];
      vid_vs <= src_vs[sel_active];
      vid_r  <= mute_c ? '0 : r_c;
      vid_g  <= mute_c ? '0 : g_c;
      vid_b  <= mute_c ? '0 : b_c;
    end
  end

endmodule

// File: doc/video_src_mux.md
Name: video_src_mux

Overview:
- Parametrised, frame-aligned video source selector for the HDMI TX path. Successor to the fixed two-way, combinational pattern-generator/HDMI-loopback select.
- Takes NUM_SRC parallel video streams of DE/HS/VS/RGB and outputs one registered stream.
- Source changes occur only at the leading edge of the active source's vertical sync, with a timeout fallback when the active source has no sync.
- Also generates the frame-aligned capture pulse and a frame counter.

Parameters:
- NUM_SRC, 4, number of input video sources (2..16).
- COLOR_W, 12, bits per colour component.
- VS_POL, 1, active level of VS on all sources (1 = active-high).
- TIMEOUT_CYC, 2000000, cycles without an active-source VS edge before the source is declared sync-less (20 ms at 100 MHz).
- INIT_SEL, 0, source selected out of reset.

Ports:
- sys_clk  in  1  pixel/system clock; all sources synchronous to it.
- rst  in  1  asynchronous, active-high reset.
- sel_in  in  $clog2(NUM_SRC)  requested source; asynchronous quasi-static level (source/probe or PIO).
- src_de  in  NUM_SRC  per-source data enable; bit i = source i.
- src_hs  in  NUM_SRC  per-source HSYNC.
- src_vs  in  NUM_SRC  per-source VSYNC.
- src_r  in  NUM_SRC*COLOR_W  red; source i at [i*COLOR_W +: COLOR_W]. Same packing for src_g and src_b.
- src_g  in  NUM_SRC*COLOR_W  green.
- src_b  in  NUM_SRC*COLOR_W  blue.
- capture_req  in  1  single-cycle request for one capture pulse.
- vid_de, vid_hs, vid_vs  out  1  selected stream timing.
- vid_r, vid_g, vid_b  out  COLOR_W  selected stream colour.
- sel_active  out  $clog2(NUM_SRC)  source currently driving the outputs.
- switch_pending  out  1  request differs from sel_active; waiting for the frame boundary.
- sel_invalid  out  1  synchronised sel_in >= NUM_SRC.
- no_sync  out  1  active source has timed out.
- capture_pulse  out  1  one-cycle capture strobe.
- frame_cnt  out  16  count of active-source frame starts.

Behaviour:
- Reset: all vid_* = 0; sel_active = INIT_SEL; state = ACTIVE; frame_cnt = 0; timeout counter = 0; capture pending = 0; all status outputs = 0.
- Selection input: sel_in passes through a 2-flop synchroniser to give sel_sync. sel_invalid = (sel_sync >= NUM_SRC). Invalid values are ignored and never switch the output.
- Frame start: vs_cur = src_vs[sel_active] XNOR VS_POL, registered into vs_prev. fs = vs_cur & ~vs_prev. On a switch, vs_prev is loaded with the new source's vs_cur in the same cycle, so the switch never produces a spurious fs.
- Timeout counter: cleared on fs and on switch; otherwise increments, saturating at TIMEOUT_CYC. no_sync = (count == TIMEOUT_CYC).
- FSM, two states:
  - ACTIVE → PENDING when sel_sync is valid and sel_sync != sel_active. switch_pending = 1 in PENDING.
  - PENDING → ACTIVE without switching if sel_sync returns to sel_active or becomes invalid.
  - PENDING → ACTIVE with switch on fs or no_sync: sel_active <= sel_sync as sampled in that cycle. Effect is visible on vid_* 2 cycles after the fs cycle (sel register, then output register).
  - fs and a sel_sync change in the same cycle: the change is only seen in the following cycle.
- Datapath: vid_* registered from mux(sel_active). Latency is 1 cycle from source inputs to outputs. DE/HS/VS/RGB are never mixed across sources within one cycle.
- frame_cnt: increments on each fs and wraps at 0xFFFF→0. Cleared to 0 on switch.
- Capture:
  - capture_req sets pending.
  - On the next fs strictly after the request cycle, capture_pulse = 1 for one cycle, in the same cycle as the frame_cnt increment, and pending clears.
  - Repeated requests before that fs merge into one pulse.
  - A switching fs does not fire the pulse; pending survives to the new source's first fs.
  - Pending clears on reset only.

Optional Feature:
- Macro VIDEO_SRC_MUX_SWITCH_MUTE_EN.
- Defined: after each switch, vid_r/g/b are forced to 0 (timing still passed) until the new source's first fs. Status output is internal only; no port change.
- Undefined: colour passes through immediately after the switch.

Decomposition:
- Shared package video_pkg:
  - SEL_W function (clog2).
  - FSM state typedef {ST_ACTIVE, ST_PENDING}.
  - FRAME_CNT_W = 16.
  - VS_ACTIVE_HIGH constant.
- One natural sub-module, vsync_edge_timeout: fs detection with reload, plus the saturating timeout counter and no_sync.

Test Plan:
1. Reset with INIT_SEL=2, then release → sel_active=2; all vid_* are 0 for 1 cycle, then follow source 2 with 1-cycle latency.
2. Set sel_in=1 mid-frame (sources 1440-cycle lines, VS every 10 lines) → switch_pending=1 until source-2 fs; vid_* show source 1 from fs+2; frame_cnt=0; no extra capture_pulse.
3. Set sel_in=3, then back to 2 before fs → switch_pending drops; sel_active stays 2; no glitch on vid_*.
4. Hold source 2 VS static, set TIMEOUT_CYC=1000, sel_in=0 → no_sync at cycle 1000 after last fs; switch completes next cycle; no_sync clears.
5. Set sel_in=5 with NUM_SRC=4 → sel_invalid=1 after 2 cycles; no switch.
6. Pulse capture_req 3 times within one frame → exactly one capture_pulse at next fs. If that fs is a switching edge, the pulse fires at the new source's first fs instead. With the macro defined, RGB reads 0 until that fs.
